instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instr_loader_if.sv | 38 +++
 rtl/xor_checksum.sv | 30 +++
 rtl/instr_loader.sv | 161 ++++++++++++++++
 tb/tb_instr_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction loader.
//   INSTR_WIDTH_DEF / DEPTH_DEF / PC_WIDTH_DEF : default word width,
//     instruction-memory depth (words) and byte-address width.
//   loader_state_t : loader FSM state encoding.
package mips_pkg;

  localparam int INSTR_WIDTH_DEF = 32;
  localparam int DEPTH_DEF       = 256;
  localparam int PC_WIDTH_DEF    = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } loader_state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Stream-in and instruction-memory write bus of the loader.
//   s_data/s_valid : incoming program stream (source -> loader)
//   s_ready        : loader accepts the current word
//   we/waddr/wdata : instruction-memory write port (loader -> memory)
// Modports: slave = loader side, master = stream source / memory side.
interface instr_loader_if
  import mips_pkg::*;
#(
  parameter int Instr_width = INSTR_WIDTH_DEF,
  parameter int PC_width    = PC_WIDTH_DEF
);

  logic [Instr_width-1:0] s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic                   we;
  logic [PC_width-1:0]    waddr;
  logic [Instr_width-1:0] wdata;

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output we,
    output waddr,
    output wdata
  );

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  we,
    input  waddr,
    input  wdata
  );

endinterface

// File: rtl/xor_checksum.sv
// Running XOR accumulator for the program checksum.
//   clk, rst  : clock, synchronous active-high reset
//   clear_i   : zero the accumulator
//   enable_i  : fold data_i into the accumulator
//   data_i    : word to accumulate
//   acc_o     : current accumulated value
module xor_checksum #(
  parameter int Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] acc_o
);

  logic [Width-1:0] acc_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      acc_q <= '0;
    end else if (enable_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/instr_loader.sv
// Program loader: receives a length word, N instruction words and a
// checksum word over a valid/ready stream, writes the instructions into
// instruction memory and releases the core from reset once the XOR
// checksum matches.
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a load (honoured in IDLE, DONE, ERR)
//   abort     : cancel a load in progress (LEN, LOAD, CHECK)
//   bus       : stream input and memory write port (instr_loader_if.slave)
//   core_rst  : hold the processor in reset (low only in DONE)
//   done      : program loaded and verified
//   error     : load failed
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN   | waiting for the length word N
// LOAD  | receiving and writing the N instruction words
// CHECK | waiting for the checksum word
// DONE  | program verified, core released
// ERR   | bad length, bad checksum or abort
module instr_loader
  import mips_pkg::*;
#(
  parameter int Instr_width = INSTR_WIDTH_DEF,
  parameter int Depth       = DEPTH_DEF,
  parameter int PC_width    = PC_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  instr_loader_if.slave bus,
  output logic          core_rst,
  output logic          done,
  output logic          error
);

  // Index and length must hold the value Depth itself.
  localparam int                     LEN_W   = $clog2(Depth + 1);
  localparam logic [LEN_W-1:0]       ONE     = LEN_W'(1);
  localparam logic [Instr_width-1:0] DEPTH_W = Instr_width'(Depth);

  loader_state_t          state_q;
  logic [LEN_W-1:0]       index_q;
  logic [LEN_W-1:0]       len_q;
  logic                   s_ready_q;
  logic                   we_q;
  logic [PC_width-1:0]    waddr_q;
  logic [Instr_width-1:0] wdata_q;
  logic                   core_rst_q;
  logic                   done_q;
  logic                   error_q;

  logic                   handshake;
  logic                   len_bad;
  logic                   last_word;
  logic                   start_ok;
  logic                   cs_enable;
  logic [Instr_width-1:0] cs_value;

  // abort gates s_ready combinationally so a word offered alongside an
  // abort is never consumed.
  assign handshake = bus.s_valid & s_ready_q & ~abort;
  assign len_bad   = (bus.s_data == '0) || (bus.s_data > DEPTH_W);
  assign last_word = (index_q == len_q - ONE);
  assign start_ok  = start & ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));
  assign cs_enable = handshake & (state_q == ST_LOAD);

  xor_checksum #(
    .Width (Instr_width)
  ) u_xor_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (start_ok),
    .enable_i (cs_enable),
    .data_i   (bus.s_data),
    .acc_o    (cs_value)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      len_q      <= '0;
      s_ready_q  <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q    <= ST_LEN;
            index_q    <= '0;
            s_ready_q  <= 1'b1;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
          end
        end
        ST_LEN: begin
          if (abort || (handshake && len_bad)) begin
            state_q   <= ST_ERR;
            s_ready_q <= 1'b0;
            error_q   <= 1'b1;
          end else if (handshake) begin
            len_q   <= bus.s_data[LEN_W-1:0];
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort) begin
            state_q   <= ST_ERR;
            s_ready_q <= 1'b0;
            error_q   <= 1'b1;
          end else if (handshake) begin
            we_q    <= 1'b1;
            wdata_q <= bus.s_data;
            waddr_q <= PC_width'({index_q, 2'b00});
            index_q <= index_q + ONE;
            if (last_word) begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (abort || (handshake && (bus.s_data != cs_value))) begin
            state_q   <= ST_ERR;
            s_ready_q <= 1'b0;
            error_q   <= 1'b1;
          end else if (handshake) begin
            state_q    <= ST_DONE;
            s_ready_q  <= 1'b0;
            core_rst_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          s_ready_q  <= 1'b0;
          core_rst_q <= 1'b1;
          done_q     <= 1'b0;
          error_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready_q & ~abort;
  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign core_rst    = core_rst_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic core_rst, done, error;

  int checks = 0;
  int passed = 0;

  logic [31:0] prog [0:2];
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];

  instr_loader_if #(.Instr_width(32), .PC_width(32)) bus ();

  instr_loader #(
    .Instr_width (32),
    .Depth       (256),
    .PC_width    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .core_rst (core_rst),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wa_q.push_back(bus.waddr);
      wd_q.push_back(bus.wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input bit gap);
    int n;
    n = 0;
    if (gap) begin
      bus.s_valid = 1'b0;
      tick();
    end
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    while (bus.s_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.s_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: s_ready=%b want 1 for word %h", bus.s_ready, d);
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_prog(input logic [31:0] cs, input bit gap);
    do_start();
    send_word(32'd3, gap);
    for (int i = 0; i < 3; i++) send_word(prog[i], gap);
    send_word(cs, gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.s_ready !== 1'b0) $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); else passed++;
    checks++; if (bus.we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.we); else passed++;
    checks++; if (bus.waddr !== 32'h0) $display("FAIL rst_waddr: got %h want 0", bus.waddr); else passed++;
    checks++; if (bus.wdata !== 32'h0) $display("FAIL rst_wdata: got %h want 0", bus.wdata); else passed++;
    checks++; if (core_rst !== 1'b1) $display("FAIL rst_core_rst: got %b want 1", core_rst); else passed++;
    checks++; if (done !== 1'b0 || error !== 1'b0) $display("FAIL rst_flags: done=%b error=%b want 0 0", done, error); else passed++;
    rst = 1'b0;
    tick();
    checks++; if (bus.s_ready !== 1'b0) $display("FAIL idle_s_ready: got %b want 0", bus.s_ready); else passed++;
  endtask

  task automatic test_good_load();
    wa_q.delete(); wd_q.delete();
    do_start();
    checks++; if (bus.s_ready !== 1'b1 || core_rst !== 1'b1) $display("FAIL good_start: s_ready=%b core_rst=%b want 1 1", bus.s_ready, core_rst); else passed++;
    send_word(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0);
    send_word(32'h01085026, 1'b0);
    checks++; if (wa_q.size() != 3) $display("FAIL good_wcount: got %0d want 3", wa_q.size()); else passed++;
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== prog[i])
        $display("FAIL good_write%0d: addr %h data %h want %h %h", i, wa_q[i], wd_q[i], 32'(i * 4), prog[i]); else passed++;
    end
    checks++; if (done !== 1'b1 || core_rst !== 1'b0 || error !== 1'b0)
      $display("FAIL good_end: done=%b core_rst=%b error=%b want 1 0 0", done, core_rst, error); else passed++;
    checks++; if (bus.s_ready !== 1'b0) $display("FAIL good_s_ready: got %b want 0", bus.s_ready); else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL done_abort: done=%b error=%b want 1 0", done, error); else passed++;
  endtask

  task automatic test_bad_checksum();
    wa_q.delete(); wd_q.delete();
    do_start();
    checks++; if (done !== 1'b0 || core_rst !== 1'b1) $display("FAIL bad_cs_start: done=%b core_rst=%b want 0 1", done, core_rst); else passed++;
    send_word(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0);
    send_word(32'h00000000, 1'b0);
    checks++; if (wa_q.size() != 3) $display("FAIL bad_cs_wcount: got %0d want 3", wa_q.size()); else passed++;
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== prog[i])
        $display("FAIL bad_cs_write%0d: addr %h data %h want %h %h", i, wa_q[i], wd_q[i], 32'(i * 4), prog[i]); else passed++;
    end
    checks++; if (error !== 1'b1 || done !== 1'b0 || core_rst !== 1'b1)
      $display("FAIL bad_cs_end: error=%b done=%b core_rst=%b want 1 0 1", error, done, core_rst); else passed++;
  endtask

  task automatic test_bad_length();
    wa_q.delete(); wd_q.delete();
    do_start();
    checks++; if (error !== 1'b0) $display("FAIL len0_start: error=%b want 0", error); else passed++;
    send_word(32'd0, 1'b0);
    tick();
    checks++; if (error !== 1'b1 || wa_q.size() != 0) $display("FAIL len0: error=%b writes=%0d want 1 0", error, wa_q.size()); else passed++;
    do_start();
    send_word(32'd257, 1'b0);
    tick();
    checks++; if (error !== 1'b1 || wa_q.size() != 0) $display("FAIL len257: error=%b writes=%0d want 1 0", error, wa_q.size()); else passed++;
  endtask

  task automatic test_single_word();
    wa_q.delete(); wd_q.delete();
    do_start();
    send_word(32'd1, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    checks++; if (wa_q.size() != 1) $display("FAIL len1_wcount: got %0d want 1", wa_q.size()); else passed++;
    if (wa_q.size() > 0) begin
      checks++; if (wa_q[0] !== 32'h0 || wd_q[0] !== 32'hDEADBEEF) $display("FAIL len1_write: addr %h data %h want 0 deadbeef", wa_q[0], wd_q[0]); else passed++;
    end
    checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL len1_end: done=%b error=%b want 1 0", done, error); else passed++;
  endtask

  task automatic test_backpressure();
    wa_q.delete(); wd_q.delete();
    load_prog(32'h01085026, 1'b1);
    checks++; if (wa_q.size() != 3) $display("FAIL bp_wcount: got %0d want 3", wa_q.size()); else passed++;
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      checks++; if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== prog[i])
        $display("FAIL bp_write%0d: addr %h data %h want %h %h", i, wa_q[i], wd_q[i], 32'(i * 4), prog[i]); else passed++;
    end
    checks++; if (done !== 1'b1 || core_rst !== 1'b0) $display("FAIL bp_end: done=%b core_rst=%b want 1 0", done, core_rst); else passed++;
  endtask

  task automatic test_reset_mid_load();
    wa_q.delete(); wd_q.delete();
    do_start();
    send_word(32'd3, 1'b0);
    send_word(prog[0], 1'b0);
    send_word(prog[1], 1'b0);
    rst = 1'b1;
    bus.s_data = prog[2];
    bus.s_valid = 1'b1;
    tick();
    checks++; if (bus.we !== 1'b0 || bus.waddr !== 32'h0 || bus.wdata !== 32'h0)
      $display("FAIL midrst_bus: we=%b waddr=%h wdata=%h want 0 0 0", bus.we, bus.waddr, bus.wdata); else passed++;
    checks++; if (bus.s_ready !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL midrst_ctl: s_ready=%b core_rst=%b done=%b error=%b want 0 1 0 0", bus.s_ready, core_rst, done, error); else passed++;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.s_valid = 1'b0;
    checks++; if (wa_q.size() != 2) $display("FAIL midrst_wcount: got %0d want 2", wa_q.size()); else passed++;
    load_prog(32'h01085026, 1'b0);
    checks++; if (done !== 1'b1 || wa_q.size() != 5) $display("FAIL midrst_reload: done=%b writes=%0d want 1 5", done, wa_q.size()); else passed++;
  endtask

  task automatic test_abort();
    wa_q.delete(); wd_q.delete();
    do_start();
    send_word(32'd3, 1'b0);
    send_word(prog[0], 1'b0);
    bus.s_data = prog[1];
    bus.s_valid = 1'b1;
    abort = 1'b1;
    #1;
    checks++; if (bus.s_ready !== 1'b0) $display("FAIL abort_s_ready: got %b want 0", bus.s_ready); else passed++;
    tick();
    checks++; if (error !== 1'b1 || bus.we !== 1'b0) $display("FAIL abort_err: error=%b we=%b want 1 0", error, bus.we); else passed++;
    abort = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    checks++; if (wa_q.size() != 1) $display("FAIL abort_wcount: got %0d want 1", wa_q.size()); else passed++;
    load_prog(32'h01085026, 1'b0);
    checks++; if (done !== 1'b1 || error !== 1'b0) $display("FAIL abort_reload: done=%b error=%b want 1 0", done, error); else passed++;
  endtask

  initial begin
    prog[0] = 32'h20080005;
    prog[1] = 32'h20090003;
    prog[2] = 32'h01095020;
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_bad_length();
    test_single_word();
    test_backpressure();
    test_reset_mid_load();
    test_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
